// File: rtl/io_port_bridge_if.sv
// Port-side bundle of the I/O bridge: host push/drain channels plus the processor IN/OUT strobes.
// Both host channels use valid/ready: a word moves on a rising clk1 edge where valid and ready are both high.
// The valid side holds its word stable until that edge, and ready never depends on valid.
interface io_port_bridge_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 4
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  logic [DATA_WIDTH-1:0] hostInData;
  logic                  hostInValid;
  logic                  hostInReady;
  logic                  inRead;
  logic [DATA_WIDTH-1:0] inputPort;
  logic                  outWrite;
  logic [DATA_WIDTH-1:0] outputPort;
  logic [DATA_WIDTH-1:0] hostOutData;
  logic                  hostOutValid;
  logic                  hostOutReady;
  logic [IAW:0]          inCount;
  logic [OAW:0]          outCount;
  logic                  inUnderflow;
  logic                  outOverflow;
  logic                  clearFlags;

  modport slave (
    input  hostInData, hostInValid, inRead, outWrite, outputPort, hostOutReady, clearFlags,
    output hostInReady, inputPort, hostOutData, hostOutValid, inCount, outCount,
           inUnderflow, outOverflow
  );

  modport master (
    output hostInData, hostInValid, inRead, outWrite, outputPort, hostOutReady, clearFlags,
    input  hostInReady, inputPort, hostOutData, hostOutValid, inCount, outCount,
           inUnderflow, outOverflow
  );
endinterface

// File: rtl/io_port_bridge.sv
// External end of the processor's I/O ports: host->IN FIFO with registered inputPort,
// OUT->host FIFO with first-word fall-through head, and sticky misuse flags.
module io_port_bridge #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 4
) (
  input  logic               clk1,
  input  logic               resetN,
  io_port_bridge_if.slave    bus
);
  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam logic [IAW:0] IN_FULL  = (IAW+1)'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);

  logic [DATA_WIDTH-1:0] in_mem_q  [IN_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_q [OUT_DEPTH];
  logic [IAW-1:0]        in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OAW-1:0]        out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [IAW:0]          in_cnt_q, in_cnt_d;
  logic [OAW:0]          out_cnt_q, out_cnt_d;
  logic [DATA_WIDTH-1:0] in_port_q, in_port_d;
  logic                  in_unf_q, in_unf_d, out_ovf_q, out_ovf_d;
  logic                  in_push, in_pop, in_empty, out_push, out_pop, out_full;

  // Ready comes from the count alone, so a full input FIFO stays closed even while IN drains it.
  assign in_empty = (in_cnt_q == '0);
  assign in_push  = bus.hostInValid && (in_cnt_q != IN_FULL);
  assign in_pop   = bus.inRead && !in_empty;
  assign out_full = (out_cnt_q == OUT_FULL);
  assign out_pop  = (out_cnt_q != '0) && bus.hostOutReady;
  assign out_push = bus.outWrite && (!out_full || out_pop);

  always_comb begin
    in_wr_d   = in_wr_q;
    in_rd_d   = in_rd_q;
    in_cnt_d  = in_cnt_q;
    in_port_d = in_port_q;
    out_wr_d  = out_wr_q;
    out_rd_d  = out_rd_q;
    out_cnt_d = out_cnt_q;
    in_unf_d  = bus.clearFlags ? 1'b0 : in_unf_q;
    out_ovf_d = bus.clearFlags ? 1'b0 : out_ovf_q;

    if (in_push) in_wr_d = in_wr_q + 1'b1;
    if (in_pop) begin
      in_rd_d   = in_rd_q + 1'b1;
      in_port_d = in_mem_q[in_rd_q];
    end
    if (in_push && !in_pop)      in_cnt_d = in_cnt_q + 1'b1;
    else if (!in_push && in_pop) in_cnt_d = in_cnt_q - 1'b1;
    if (bus.inRead && in_empty)  in_unf_d = 1'b1;

    if (out_push) out_wr_d = out_wr_q + 1'b1;
    if (out_pop)  out_rd_d = out_rd_q + 1'b1;
    if (out_push && !out_pop)      out_cnt_d = out_cnt_q + 1'b1;
    else if (!out_push && out_pop) out_cnt_d = out_cnt_q - 1'b1;
    if (bus.outWrite && out_full && !out_pop) out_ovf_d = 1'b1;
  end

  always_ff @(posedge clk1 or negedge resetN) begin
    if (!resetN) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      in_port_q <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
      in_unf_q  <= 1'b0;
      out_ovf_q <= 1'b0;
      for (int i = 0; i < IN_DEPTH; i++)  in_mem_q[i]  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) out_mem_q[i] <= '0;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      in_port_q <= in_port_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
      in_unf_q  <= in_unf_d;
      out_ovf_q <= out_ovf_d;
      if (in_push)  in_mem_q[in_wr_q]   <= bus.hostInData;
      if (out_push) out_mem_q[out_wr_q] <= bus.outputPort;
    end
  end

  assign bus.hostInReady  = (in_cnt_q != IN_FULL);
  assign bus.inputPort    = in_port_q;
  assign bus.inCount      = in_cnt_q;
  assign bus.outCount     = out_cnt_q;
  assign bus.hostOutValid = (out_cnt_q != '0);
  assign bus.hostOutData  = (out_cnt_q != '0) ? out_mem_q[out_rd_q] : '0;
  assign bus.inUnderflow  = in_unf_q;
  assign bus.outOverflow  = out_ovf_q;
endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
- Peripheral on the far side of the processor's 16-bit I/O ports. It owns the external end of both port directions.
- Input direction: the host pushes words into an input FIFO, and the processor's IN instruction pops them onto inputPort.
- Output direction: the processor's OUT instruction pushes outputPort into an output FIFO, which the host drains through a valid/ready handshake.
- The bridge sits beside the processor top level and uses the stage/memory clock domain.

Parameters:
DATA_WIDTH, 16, width of every data path
IN_DEPTH, 4, input FIFO entries (power of two, >=2)
OUT_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk1  in  1  the single clock; all state updates on its rising edge
resetN  in  1  reset, asynchronous and active-low
hostInData  in  DATA_WIDTH  word offered by the host
hostInValid  in  1  host word valid
hostInReady  out  1  input FIFO can accept
inRead  in  1  one-cycle pulse from processor IN execution
inputPort  out  DATA_WIDTH  registered word delivered to the processor
outWrite  in  1  one-cycle pulse from processor OUT execution
outputPort  in  DATA_WIDTH  processor word to emit
hostOutData  out  DATA_WIDTH  head of output FIFO
hostOutValid  out  1  output FIFO non-empty
hostOutReady  in  1  host accepts head
inCount  out  log2(IN_DEPTH)+1  input FIFO occupancy
outCount  out  log2(OUT_DEPTH)+1  output FIFO occupancy
inUnderflow  out  1  sticky: IN executed with input FIFO empty
outOverflow  out  1  sticky: OUT executed with output FIFO full
clearFlags  in  1  clears both sticky flags

Behaviour:
- Reset (resetN low, asynchronous, any time including mid-transfer):
  - Both FIFOs emptied; read/write pointers and counts go to 0.
  - inputPort=0, inUnderflow=0, outOverflow=0.
  - hostOutValid=0, and hostOutData reads as 0 while empty.
  - hostInReady=1 once the input FIFO is empty after reset.
  - No stored data survives reset.
- Input FIFO push:
  - A push occurs when hostInValid and hostInReady are both high at the edge.
  - hostInReady = (inCount != IN_DEPTH). It is combinational from the count and does not depend on inRead in the same cycle (no full-bypass).
- Input FIFO pop (inRead high at the edge):
  - If inCount != 0: inputPort <= head, read pointer advances. The value is visible on inputPort one cycle after the inRead edge.
  - If inCount == 0: inputPort holds its previous value, inUnderflow <= 1, no pointer change. This holds even if a push happens in the same cycle; the pushed word is stored for a later IN.
  - Simultaneous push and pop on a non-empty, non-full FIFO: inCount unchanged and both pointers advance.
  - inputPort changes only on a successful pop.
- Output FIFO push (outWrite high at the edge):
  - If not full, or full with a pop in the same cycle: store outputPort, write pointer advances.
  - If full with no same-cycle pop: the word is dropped and outOverflow <= 1.
- Output FIFO head (first-word fall-through):
  - hostOutData = head entry; hostOutValid = (outCount != 0).
  - Pop occurs when hostOutValid and hostOutReady are both high.
  - A word written to an empty FIFO appears on hostOutData the cycle after the outWrite edge.
- Pointers wrap modulo depth. Counts range 0..DEPTH, with increment/decrement resolved in one update (push+pop leaves the count unchanged).
- Flags:
  - clearFlags high at the edge clears both flags.
  - If a flag-setting event occurs in the same cycle, set wins.
  - Flags never clear otherwise.
- No X propagation: the data registers' reset value is 0.

Test Plan:
- Reset then push 0x1111, 0x2222, 0x3333, 0x4444 -> hostInReady=0 after the fourth push, inCount=4. A fifth word 0x5555 is held off until one IN pop.
- inRead on the FIFO above -> inputPort=0x1111 one cycle later, then 0x2222 on the next inRead. inCount decrements each time and hostInReady returns to 1.
- inRead with the input FIFO empty and inputPort=0x2222 -> inputPort stays 0x2222 and inUnderflow=1. clearFlags -> 0. clearFlags plus an empty inRead in the same cycle -> flag stays 1.
- outWrite 0xAAAA, 0xBBBB with hostOutReady=0 -> hostOutValid=1, hostOutData=0xAAAA, outCount=2. Raise hostOutReady -> 0xAAAA then 0xBBBB, then valid drops.
- Fill the output FIFO with 4 words, then outWrite 0xDEAD with hostOutReady=0 -> dropped, outOverflow=1, outCount=4. Repeat with hostOutReady=1 -> accepted, no overflow, outCount stays 4.
- Assert resetN low mid-stream with both FIFOs partially full -> all counts 0, inputPort=0, hostOutValid=0 immediately (asynchronous), and flags 0.
